// File: rtl/f1_pkg.sv
// Shared types and helpers for the F1 start-light monitor.
// Thermometer patterns are built LSB-first.
package f1_pkg;

  localparam int F1_N_LIGHTS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUILD,
    S_ARMED,
    S_TIMING,
    S_PENALTY,
    S_FAULT
  } f1_mon_state_t;

  function automatic logic [31:0] thermo(input int unsigned k);
    if (k >= 32) return '1;
    return (32'd1 << k) - 32'd1;
  endfunction

  function automatic logic is_thermo(input logic [31:0] p);
    return (p & (p + 32'd1)) == 32'd0;
  endfunction

endpackage

// File: rtl/f1_reaction_counter.sv
// Tick counter for reaction timing; holds at MAX_TIME and
// flags the increment that reaches it.
module f1_reaction_counter
  import f1_pkg::*;
#(
  parameter int TIME_W   = 16,
  parameter int MAX_TIME = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [TIME_W-1:0] count_o,
  output logic              hit_o
);

  localparam logic [TIME_W-1:0] MAX_V = TIME_W'(MAX_TIME);
  localparam logic [TIME_W-1:0] ONE   = TIME_W'(1);

  logic [TIME_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;
  assign hit_o   = en_i && !clr_i && (cnt_q == MAX_V - ONE);

endmodule

// File: rtl/f1_light_monitor.sv
// Start-light bar checker and driver reaction timer.
// FSM, trigger edge detect and all outputs are registered here.
module f1_light_monitor
  import f1_pkg::*;
#(
  parameter int N_LIGHTS = F1_N_LIGHTS,
  parameter int TIME_W   = 16,
  parameter int MAX_TIME = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_LIGHTS-1:0] lights,
  input  logic                tick,
  input  logic                trigger,
  output logic [3:0]          level,
  output logic                armed,
  output logic                result_valid,
  output logic [TIME_W-1:0]   reaction_time,
  output logic                false_start,
  output logic                timeout,
  output logic                pattern_err
);

  localparam logic [3:0] N_LV = 4'(N_LIGHTS);

  f1_mon_state_t     state_q;
  logic [3:0]        level_q;
  logic              armed_q, rv_q, fs_q, to_q, perr_q;
  logic [TIME_W-1:0] rt_q;
  logic              trig_q;

  logic              trig_rise;
  logic [3:0]        lvl_nxt;
  logic [N_LIGHTS-1:0] th_cur, th_nxt, th_one;
  logic [TIME_W-1:0] count;
  logic              hit;

  assign trig_rise = trigger & ~trig_q;
  assign lvl_nxt   = level_q + 4'd1;
  assign th_cur    = N_LIGHTS'(thermo(32'(level_q)));
  assign th_nxt    = N_LIGHTS'(thermo(32'(lvl_nxt)));
  assign th_one    = N_LIGHTS'(1);

  // Counter is held clear outside TIMING, so the lights-out
  // edge itself never counts a coincident tick.
  f1_reaction_counter #(
    .TIME_W  (TIME_W),
    .MAX_TIME(MAX_TIME)
  ) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q != S_TIMING),
    .en_i   (tick),
    .count_o(count),
    .hit_o  (hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      level_q <= '0;
      armed_q <= 1'b0;
      rv_q    <= 1'b0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
      perr_q  <= 1'b0;
      rt_q    <= '0;
      trig_q  <= 1'b1;
    end else begin
      trig_q <= trigger;
      rv_q   <= 1'b0;
      fs_q   <= 1'b0;
      to_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (lights == th_one) begin
            level_q <= 4'd1;
            if (N_LV == 4'd1) begin
              state_q <= S_ARMED;
              armed_q <= 1'b1;
            end else begin
              state_q <= S_BUILD;
            end
          end else if (lights != '0) begin
            state_q <= S_FAULT;
            perr_q  <= 1'b1;
            level_q <= '0;
          end
        end
        S_BUILD: begin
          if (lights == th_cur) begin
            state_q <= S_BUILD;
          end else if (lights == th_nxt) begin
            level_q <= lvl_nxt;
            if (lvl_nxt == N_LV) begin
              state_q <= S_ARMED;
              armed_q <= 1'b1;
            end
          end else begin
            state_q <= S_FAULT;
            perr_q  <= 1'b1;
            level_q <= '0;
          end
        end
        S_ARMED: begin
          if (trig_rise) begin
            state_q <= S_PENALTY;
            fs_q    <= 1'b1;
            armed_q <= 1'b0;
          end else if (lights == '0) begin
            state_q <= S_TIMING;
            level_q <= '0;
            armed_q <= 1'b0;
          end else if (lights != '1) begin
            state_q <= S_FAULT;
            perr_q  <= 1'b1;
            level_q <= '0;
            armed_q <= 1'b0;
          end
        end
        S_TIMING: begin
          if (trig_rise) begin
            state_q <= S_IDLE;
            rv_q    <= 1'b1;
            rt_q    <= count;
          end else if (hit) begin
            state_q <= S_IDLE;
            to_q    <= 1'b1;
          end else if (lights != '0) begin
            state_q <= S_FAULT;
            perr_q  <= 1'b1;
          end
        end
        S_PENALTY: begin
          if (lights == '0) begin
            state_q <= S_IDLE;
            level_q <= '0;
          end
        end
        S_FAULT: begin
          level_q <= '0;
          if (lights == '0) begin
            state_q <= S_IDLE;
            perr_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign level         = level_q;
  assign armed         = armed_q;
  assign result_valid  = rv_q;
  assign reaction_time = rt_q;
  assign false_start   = fs_q;
  assign timeout       = to_q;
  assign pattern_err   = perr_q;

endmodule

// File: tb/tb_f1_light_monitor.sv
// Directed/randomized bench for f1_light_monitor; expected values
// come from tick counts and light-bar rules computed here.
module tb_f1_light_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  lights = '0;
  logic        tick = 1'b0;
  logic        trigger = 1'b1;
  logic [3:0]  level;
  logic        armed;
  logic        result_valid;
  logic [15:0] reaction_time;
  logic        false_start;
  logic        timeout;
  logic        pattern_err;

  int checks = 0;
  int failures = 0;
  int rv_cnt = 0;
  int fs_cnt = 0;
  int to_cnt = 0;
  int last_rt = 0;

  always #5 clk = ~clk;

  f1_light_monitor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lights       (lights),
    .tick         (tick),
    .trigger      (trigger),
    .level        (level),
    .armed        (armed),
    .result_valid (result_valid),
    .reaction_time(reaction_time),
    .false_start  (false_start),
    .timeout      (timeout),
    .pattern_err  (pattern_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
    rv_cnt += int'(result_valid);
    fs_cnt += int'(false_start);
    to_cnt += int'(timeout);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bar(input int k);
    logic [8:0] v;
    v = (9'd1 << k) - 9'd1;
    return v[7:0];
  endfunction

  task automatic build();
    for (int k = 1; k <= 8; k++) begin
      int hold;
      hold = int'($urandom_range(1, 3));
      lights = bar(k);
      step();
      chk($sformatf("build_level%0d", k), 32'(level), 32'(k));
      repeat (hold - 1) step();
    end
    chk("build_armed", 32'(armed), 32'd1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic timed_run(input int n, input bit same_cycle);
    int rv0;
    build();
    lights = 8'h00;
    step();
    chk("out_armed", 32'(armed), 32'd0);
    chk("out_level", 32'(level), 32'd0);
    ticks(n);
    rv0 = rv_cnt;
    trigger = 1'b1;
    tick = same_cycle;
    step();
    tick = 1'b0;
    chk("run_rv", 32'(result_valid), 32'd1);
    chk("run_rt", 32'(reaction_time), 32'(n));
    last_rt = n;
    trigger = 1'b0;
    step();
    chk("run_rv_width", 32'(rv_cnt - rv0), 32'd1);
    chk("run_rt_hold", 32'(reaction_time), 32'(n));
    chk("run_level", 32'(level), 32'd0);
  endtask

  initial begin
    int rv0, fs0, to0;

    #3;
    step();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_pulses", 32'({result_valid, false_start, timeout}), 32'd0);
    chk("rst_flags", 32'({armed, pattern_err}), 32'd0);
    chk("rst_rt", 32'(reaction_time), 32'd0);
    rst_n = 1'b1;
    fs0 = fs_cnt;
    repeat (2) step();
    trigger = 1'b0;
    step();

    timed_run(37, 1'b0);
    timed_run(5, 1'b1);
    timed_run(int'($urandom_range(1, 80)), 1'($urandom_range(0, 1)));

    build();
    fs0 = fs_cnt;
    rv0 = rv_cnt;
    trigger = 1'b1;
    step();
    chk("fs_pulse", 32'(false_start), 32'd1);
    chk("fs_armed", 32'(armed), 32'd0);
    step();
    trigger = 1'b0;
    step();
    trigger = 1'b1;
    step();
    chk("fs_once", 32'(fs_cnt - fs0), 32'd1);
    trigger = 1'b0;
    lights = 8'h00;
    step();
    chk("fs_idle_level", 32'(level), 32'd0);
    chk("fs_no_rv", 32'(rv_cnt - rv0), 32'd0);

    build();
    rv0 = rv_cnt;
    lights = 8'h00;
    trigger = 1'b1;
    step();
    chk("same_fs", 32'(false_start), 32'd1);
    trigger = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    chk("same_no_rv", 32'(rv_cnt - rv0), 32'd0);

    build();
    lights = 8'h00;
    step();
    to0 = to_cnt;
    rv0 = rv_cnt;
    for (int i = 0; i < 999; i++) begin
      tick = 1'b1;
      step();
    end
    chk("to_early", 32'(to_cnt - to0), 32'd0);
    step();
    chk("to_pulse", 32'(timeout), 32'd1);
    chk("to_rt_hold", 32'(reaction_time), 32'(last_rt));
    tick = 1'b0;
    step();
    chk("to_width", 32'(timeout), 32'd0);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    chk("to_no_rv", 32'(rv_cnt - rv0), 32'd0);

    lights = 8'h01;
    step();
    chk("skip_lvl1", 32'(level), 32'd1);
    lights = 8'h07;
    step();
    chk("skip_perr", 32'(pattern_err), 32'd1);
    chk("skip_level", 32'(level), 32'd0);
    lights = 8'h00;
    step();
    chk("skip_clear", 32'(pattern_err), 32'd0);

    for (int k = 1; k <= 4; k++) begin
      lights = bar(k);
      step();
    end
    chk("mid_lvl4", 32'(level), 32'd4);
    lights = 8'h00;
    step();
    chk("mid_perr", 32'(pattern_err), 32'd1);
    chk("mid_level", 32'(level), 32'd0);
    step();
    chk("mid_clear", 32'(pattern_err), 32'd0);

    build();
    lights = 8'h00;
    step();
    ticks(3);
    lights = 8'h01;
    step();
    chk("timing_perr", 32'(pattern_err), 32'd1);
    lights = 8'h00;
    step();
    chk("timing_clear", 32'(pattern_err), 32'd0);

    build();
    lights = 8'h00;
    step();
    ticks(12);
    trigger = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rt", 32'(reaction_time), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_pulses", 32'({result_valid, false_start, timeout}), 32'd0);
    chk("arst_flags", 32'({armed, pattern_err}), 32'd0);
    rv0 = rv_cnt;
    fs0 = fs_cnt;
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("arst_no_rv", 32'(rv_cnt - rv0), 32'd0);
    chk("arst_no_fs", 32'(fs_cnt - fs0), 32'd0);
    chk("arst_rt_after", 32'(reaction_time), 32'd0);
    trigger = 1'b0;
    step();

    timed_run(int'($urandom_range(1, 40)), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
